// File: rtl/filter_seq_pkg.sv
// Shared types and defaults for the pulse-shaping filter sequencer.
package filter_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef logic [1:0] sym_t;

  localparam int SPS_DEF       = 8;
  localparam int LATENCY_DEF   = 70;
  localparam int CW_DEF        = 7;
  localparam int SYMS_PER_BYTE = 4;

  // Symbol 0 is taken from the top two bits of the byte.
  localparam bit SYM_MSB_FIRST = 1'b1;

  function automatic sym_t sym_of(input logic [7:0] b, input logic [1:0] k);
    logic [1:0] j;
    logic [7:0] s;
    j = SYM_MSB_FIRST ? k : ~k;
    s = b << {j, 1'b0};
    return s[7:6];
  endfunction

endpackage

// File: rtl/filter_seq_if.sv
// Byte-stream input, filter drive and DAC-side flag bundle for filter_seq.
interface filter_seq_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       out_ready;
  logic       gate;
  logic       bit1;
  logic       bit2;
  logic       out_valid;
  logic       out_last;
  logic       busy;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, gate, bit1, bit2, out_valid, out_last, busy
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, gate, bit1, bit2, out_valid, out_last, busy
  );
endinterface

// File: rtl/filter_seq_ser.sv
// Byte serialiser: holds one byte and steps its four symbols, SPS gated
// cycles each, onto bit1/bit2.
module filter_seq_ser
  import filter_seq_pkg::*;
#(
  parameter int SPS = SPS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gate,
  input  logic       accept_ok,
  input  logic       drain,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       load,
  output logic       full,
  output logic       final_cyc,
  output logic       bit1,
  output logic       bit2
);

  localparam int          SW       = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [SW-1:0] SPS_LAST = SW'(SPS - 1);

  logic [7:0]    byte_q;
  logic [1:0]    sym_idx;
  logic [SW-1:0] sps_cnt;

  assign final_cyc = gate && full && (sym_idx == 2'd3) && (sps_cnt == SPS_LAST);
  // Reload on the last gated cycle of the current byte keeps the filter fed
  // without a bubble.
  assign in_ready  = accept_ok && (!full || final_cyc);
  assign load      = in_ready && in_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_q       <= '0;
      full         <= 1'b0;
      sym_idx      <= '0;
      sps_cnt      <= '0;
      {bit1, bit2} <= 2'b00;
    end else if (load) begin
      byte_q       <= in_data;
      full         <= 1'b1;
      sym_idx      <= '0;
      sps_cnt      <= '0;
      {bit1, bit2} <= sym_of(in_data, 2'd0);
    end else if (gate && full) begin
      if (sps_cnt == SPS_LAST) begin
        sps_cnt <= '0;
        sym_idx <= sym_idx + 2'd1;
        if (sym_idx == 2'd3) begin
          full <= 1'b0;
          // Frame tail feeds zeros; an underrun just holds the last symbol.
          if (drain) {bit1, bit2} <= 2'b00;
        end else begin
          {bit1, bit2} <= sym_of(byte_q, sym_idx + 2'd1);
        end
      end else begin
        sps_cnt <= sps_cnt + SW'(1);
      end
    end
  end

endmodule

// File: rtl/filter_seq.sv
// Filter sequencer: gates the filter clock, hides pipeline fill latency and
// flushes the tail so the sink sees exactly one sample per data cycle.
module filter_seq
  import filter_seq_pkg::*;
#(
  parameter int SPS     = SPS_DEF,
  parameter int LATENCY = LATENCY_DEF,
  parameter int CW      = CW_DEF
) (
  input  logic         clk,
  input  logic         rst,
  filter_seq_if.slave  bus
);

  localparam logic [CW-1:0] FILL_MAX   = CW'(LATENCY);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(LATENCY - 1);

  state_t        state, state_nx;
  logic          armed;
  logic          last_flag;
  logic          accept_ok;
  logic          load;
  logic          full;
  logic          final_cyc;
  logic          gate;
  logic          out_last;
  logic [CW-1:0] fill_cnt;
  logic [CW-1:0] flush_cnt;

  filter_seq_ser #(.SPS(SPS)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .gate      (gate),
    .accept_ok (accept_ok),
    .drain     (last_flag),
    .in_data   (bus.in_data),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .load      (load),
    .full      (full),
    .final_cyc (final_cyc),
    .bit1      (bus.bit1),
    .bit2      (bus.bit2)
  );

  // armed keeps in_ready low while reset is held.
  assign accept_ok = armed && !last_flag && (state != ST_FLUSH);
  assign gate      = bus.out_ready &&
                     (((state == ST_RUN) && full) || (state == ST_FLUSH));

  assign bus.gate      = gate;
  assign bus.out_valid = gate && (fill_cnt == FILL_MAX);
  assign bus.out_last  = out_last;
  assign bus.busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    out_last = 1'b0;
    unique case (state)
      ST_IDLE:  if (load) state_nx = ST_RUN;
      ST_RUN:   if (final_cyc && last_flag) state_nx = ST_FLUSH;
      ST_FLUSH: begin
        if (gate && (flush_cnt == FLUSH_LAST)) begin
          out_last = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed     <= 1'b0;
      last_flag <= 1'b0;
      fill_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      armed <= 1'b1;

      if (load)          last_flag <= bus.in_last;
      else if (out_last) last_flag <= 1'b0;

      // fill_cnt reaching LATENCY marks the first filter output carrying data.
      if (out_last)                          fill_cnt <= '0;
      else if (gate && fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + CW'(1);

      if (state != ST_FLUSH) flush_cnt <= '0;
      else if (gate)         flush_cnt <= flush_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_filter_seq.sv
// Directed bench for filter_seq: one initial block of frames with
// hand-computed gated-cycle positions, symbol values and sample counts.
module tb_filter_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;

  filter_seq_if bus();

  filter_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] frame [4];
  logic [7:0] next_byte;
  logic [1:0] gap_expect;
  logic [1:0] sym_log [0:511];

  int g, v, l, first_v, last_v, last_g, last_c, hs2_c, c0;
  int gap, gap_bad, bp_bad, ungated;
  logic busy_after;
  bit done;
  int hs_g[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] outs_now();
    return {25'd0, bus.gate, bus.bit1, bus.bit2, bus.out_valid,
            bus.out_last, bus.busy, bus.in_ready};
  endfunction

  // Drives one frame cycle by cycle and records what the sink/filter see.
  task automatic run_frame(input int nb, input int late, input bit bp,
                           input bit hold_next, input int rst_at_g);
    int  bi;
    bit  post;
    bit  tog;
    bi = 0; post = 0; tog = 1;
    g = 0; v = 0; l = 0; first_v = 0; last_v = 0; last_g = 0; last_c = -1;
    hs2_c = -1; c0 = 0; gap = 0; gap_bad = 0; bp_bad = 0; ungated = 0;
    busy_after = 1'b1; done = 0;
    hs_g.delete();
    for (int k = 0; k < 3000 && !done; k++) begin
      bus.in_valid  = (bi < nb && (bi != 1 || late < 0 || cyc >= c0 + 32 + late)) ||
                      (hold_next && bi >= nb);
      bus.in_data   = (bi < nb) ? frame[bi] : next_byte;
      bus.in_last   = (bi >= nb - 1);
      bus.out_ready = bp ? tog : 1'b1;
      tog = ~tog;
      @(negedge clk);
      if (bus.gate) begin
        g++;
        if (g < 512) sym_log[g] = {bus.bit1, bus.bit2};
        if (bus.out_valid) begin
          v++;
          if (first_v == 0) first_v = g;
          last_v = g;
        end
      end else if (bus.out_valid || bus.out_last) begin
        ungated++;
      end
      if (bp && bus.busy && bus.gate !== bus.out_ready) bp_bad++;
      if (!bp && bus.busy && !bus.gate) begin
        gap++;
        if ({bus.bit1, bus.bit2} !== gap_expect) gap_bad++;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (bi < nb) begin
          if (bi == 0) c0 = cyc;
          hs_g.push_back(bus.gate ? g : 0);
          bi++;
        end else if (hs2_c < 0) begin
          hs2_c = cyc;
        end
      end
      if (post) begin
        busy_after = bus.busy;
        done = 1;
      end else if (bus.out_last) begin
        l++;
        last_g = g;
        last_c = cyc;
        post = 1;
      end
      if (rst_at_g > 0 && g == rst_at_g && !done) begin
        chk("pre_rst_bits", sym_log[g], 2'b11);
        #2 rst = 1'b0;
        #1 chk("rst_async_outs", outs_now(), 32'd0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        done = 1;
      end
      tick();
    end
    chk("frame_done", done, 1);
  endtask

  logic [1:0] b4_sym [4];

  initial begin
    b4_sym[0] = 2'b10; b4_sym[1] = 2'b11; b4_sym[2] = 2'b01; b4_sym[3] = 2'b00;
    gap_expect = 2'b00;
    next_byte  = 8'h00;

    // Reset with stimulus active: every output must still be low.
    bus.in_valid = 1'b1; bus.in_data = 8'hFF; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    #1 chk("reset_outs", outs_now(), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    chk("idle_in_ready", bus.in_ready, 1);
    chk("idle_busy", bus.busy, 0);

    // Single byte 0xB4
    frame[0] = 8'hB4;
    run_frame(1, -1, 0, 0, 0);
    for (int s = 0; s < 4; s++) begin
      chk("b4_sym_first", sym_log[8*s + 1], b4_sym[s]);
      chk("b4_sym_last",  sym_log[8*s + 8], b4_sym[s]);
    end
    chk("b4_gated", g, 102);
    chk("b4_valid", v, 32);
    chk("b4_first_valid", first_v, 71);
    chk("b4_last_valid", last_v, 102);
    chk("b4_last_cnt", l, 1);
    chk("b4_last_pos", last_g, 102);
    chk("b4_busy_after", busy_after, 0);
    chk("b4_ungated", ungated, 0);

    // Four back-to-back bytes, in_valid held
    frame[0] = 8'h1B; frame[1] = 8'hE4; frame[2] = 8'hCC; frame[3] = 8'h33;
    run_frame(4, -1, 0, 0, 0);
    chk("f4_hs_cnt", hs_g.size(), 4);
    chk("f4_hs1", hs_g[1], 32);
    chk("f4_hs2", hs_g[2], 64);
    chk("f4_hs3", hs_g[3], 96);
    chk("f4_gap", gap, 0);
    chk("f4_gated", g, 198);
    chk("f4_valid", v, 128);
    chk("f4_first_valid", first_v, 71);
    chk("f4_last_valid", last_v, 198);
    chk("f4_last_cnt", l, 1);
    chk("f4_sym32", sym_log[32], 2'b11);
    chk("f4_sym33", sym_log[33], 2'b11);
    chk("f4_sym64", sym_log[64], 2'b00);
    chk("f4_sym65", sym_log[65], 2'b11);
    chk("f4_sym97", sym_log[97], 2'b00);
    chk("f4_sym128", sym_log[128], 2'b11);
    chk("f4_flush_bits", sym_log[129], 2'b00);

    // Underrun: second byte offered 5 cycles after the first byte ends
    frame[0] = 8'h1B; frame[1] = 8'h8D;
    gap_expect = 2'b11;
    run_frame(2, 5, 0, 0, 0);
    chk("ur_gap", gap, 5);
    chk("ur_gap_bits", gap_bad, 0);
    chk("ur_hs_cnt", hs_g.size(), 2);
    chk("ur_sym33", sym_log[33], 2'b10);
    chk("ur_gated", g, 134);
    chk("ur_valid", v, 64);
    chk("ur_last_cnt", l, 1);
    gap_expect = 2'b00;

    // Back-pressure: out_ready alternates every cycle
    frame[0] = 8'hB4;
    run_frame(1, -1, 1, 0, 0);
    chk("bp_gate_eq_ready", bp_bad, 0);
    chk("bp_gated", g, 102);
    chk("bp_valid", v, 32);
    chk("bp_last_cnt", l, 1);
    chk("bp_ungated", ungated, 0);

    // Reset 40 gated cycles into a 2-byte frame, then a fresh 0x00 frame
    frame[0] = 8'hFF; frame[1] = 8'hFF;
    run_frame(2, -1, 0, 0, 40);
    chk("rst_no_last", l, 0);
    frame[0] = 8'h00;
    run_frame(1, -1, 0, 0, 0);
    chk("fresh_gated", g, 102);
    chk("fresh_valid", v, 32);
    chk("fresh_first_valid", first_v, 71);
    chk("fresh_last_pos", last_g, 102);
    chk("fresh_sym1", sym_log[1], 2'b00);

    // Next frame's byte offered during the last byte: waits for IDLE
    frame[0]  = 8'hB4;
    next_byte = 8'h5A;
    run_frame(1, -1, 0, 1, 0);
    chk("hold_hs_cnt", hs_g.size(), 1);
    chk("hold_accept_cycle", hs2_c, last_c + 1);
    chk("hold_last_cnt", l, 1);
    run_frame(0, -1, 0, 0, 0);
    chk("next_sym1", sym_log[1], 2'b01);
    chk("next_sym17", sym_log[17], 2'b10);
    chk("next_valid", v, 32);
    chk("next_last_cnt", l, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
